// File: rtl/alu_8bit_if.sv
// Operand/result bundle for the 8-bit ALU.
// master drives operands and opcode; slave returns the registered result.
interface alu_8bit_if;
    logic [7:0] a;
    logic [7:0] b;
    logic [2:0] alu_sel;
    logic [7:0] alu_out;
    logic       carry_out;

    modport master (
        output a,
        output b,
        output alu_sel,
        input  alu_out,
        input  carry_out
    );

    modport slave (
        input  a,
        input  b,
        input  alu_sel,
        output alu_out,
        output carry_out
    );
endinterface

// File: rtl/alu_8bit.sv
// 8-bit ALU with one-cycle registered result and carry/borrow/shift-out flag.
// Eight opcodes: add, sub, and, or, xor, not, shl, shr.
module alu_8bit (
    input logic       clk,
    input logic       rst_n,
    alu_8bit_if.slave bus
);
    logic [7:0] res_d;
    logic       carry_d;
    logic [8:0] sum;
    logic [8:0] diff;

    // Wide add/sub so the ninth bit carries the lost carry or borrow.
    assign sum  = {1'b0, bus.a} + {1'b0, bus.b};
    assign diff = {1'b0, bus.a} - {1'b0, bus.b};

    // Opcode decode: every code is defined, so no fallback value is reachable.
    always_comb begin
        res_d   = 8'h00;
        carry_d = 1'b0;
        case (bus.alu_sel)
            3'b000: begin
                res_d   = sum[7:0];
                carry_d = sum[8];
            end
            3'b001: begin
                res_d   = diff[7:0];
                carry_d = diff[8];
            end
            3'b010: res_d = bus.a & bus.b;
            3'b011: res_d = bus.a | bus.b;
            3'b100: res_d = bus.a ^ bus.b;
            3'b101: res_d = ~bus.a;
            3'b110: begin
                res_d   = {bus.a[6:0], 1'b0};
                carry_d = bus.a[7];
            end
            3'b111: begin
                res_d   = {1'b0, bus.a[7:1]};
                carry_d = bus.a[0];
            end
            default: begin
                res_d   = 8'h00;
                carry_d = 1'b0;
            end
        endcase
    end

    // Output register; reset clears the result and drops any pending one.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.alu_out   <= 8'h00;
            bus.carry_out <= 1'b0;
        end else begin
            bus.alu_out   <= res_d;
            bus.carry_out <= carry_d;
        end
    end
endmodule

// File: tb/tb_alu_8bit.sv
// Randomised self-checking bench for alu_8bit.
// Expected values come from an integer-arithmetic model of the opcode table.
module tb_alu_8bit;
    logic clk;
    logic rst_n;
    int   total;
    int   bad;

    alu_8bit_if bus ();

    alu_8bit dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: {carry, result} computed with plain integer arithmetic.
    function automatic logic [8:0] ref_op(input int x, input int y,
                                          input int s);
        int r;
        int c;
        r = 0;
        c = 0;
        case (s)
            0: begin r = x + y; c = (r > 255) ? 1 : 0; r = r % 256; end
            1: begin r = x - y; c = (r < 0) ? 1 : 0; r = (r + 256) % 256; end
            2: r = x & y;
            3: r = x | y;
            4: r = x ^ y;
            5: r = 255 - x;
            6: begin r = x * 2; c = (r > 255) ? 1 : 0; r = r % 256; end
            default: begin r = x / 2; c = x % 2; end
        endcase
        return 9'(c * 256 + r);
    endfunction

    task automatic chk(input string tag, input logic [8:0] got,
                       input logic [8:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got c=%0b out=%02h, want c=%0b out=%02h",
                     tag, got[8], got[7:0], exp[8], exp[7:0]);
        end
    endtask

    function automatic logic [8:0] obs();
        return {bus.carry_out, bus.alu_out};
    endfunction

    // Drive one operation mid-cycle, check it one edge later.
    task automatic step(input logic [7:0] ta, input logic [7:0] tb_v,
                        input logic [2:0] ts, input string tag);
        bus.a = ta;
        bus.b = tb_v;
        bus.alu_sel = ts;
        @(posedge clk);
        #1;
        chk(tag, obs(), ref_op(int'(ta), int'(tb_v), int'(ts)));
    endtask

    // Checks against hand-derived constants from the opcode table.
    task automatic step_k(input logic [7:0] ta, input logic [7:0] tb_v,
                          input logic [2:0] ts, input logic [8:0] k,
                          input string tag);
        bus.a = ta;
        bus.b = tb_v;
        bus.alu_sel = ts;
        @(posedge clk);
        #1;
        chk(tag, obs(), k);
    endtask

    initial begin
        logic [8:0] held;
        logic [8:0] sweep_k [8];
        total = 0;
        bad = 0;
        sweep_k = '{9'h06E, 9'h000, 9'h037, 9'h037,
                    9'h000, 9'h0C8, 9'h06E, 9'h11B};

        rst_n = 1'b0;
        bus.a = 8'h37;
        bus.b = 8'h37;
        bus.alu_sel = 3'b000;
        #2;
        chk("reset_init", obs(), 9'h000);
        @(posedge clk);
        #1;
        chk("reset_held", obs(), 9'h000);
        rst_n = 1'b1;
        #2;
        chk("release_pre", obs(), 9'h000);
        step_k(8'h37, 8'h37, 3'b000, 9'h06E, "first_add");

        for (int i = 0; i < 8; i++)
            step_k(8'h37, 8'h37, 3'(i), sweep_k[i], $sformatf("sweep%0d", i));

        step_k(8'hFF, 8'h01, 3'b000, 9'h100, "add_wrap_ff");
        step_k(8'h80, 8'h80, 3'b000, 9'h100, "add_wrap_80");
        step_k(8'h05, 8'h07, 3'b001, 9'h1FE, "sub_borrow");
        step_k(8'h07, 8'h05, 3'b001, 9'h002, "sub_noborrow");
        step_k(8'h81, 8'h00, 3'b110, 9'h102, "shl_81");
        step_k(8'h81, 8'h00, 3'b111, 9'h140, "shr_81");
        step_k(8'h00, 8'h5A, 3'b110, 9'h000, "shl_00");
        step_k(8'h00, 8'h5A, 3'b111, 9'h000, "shr_00");

        // Inputs wiggled between edges must not reach the outputs.
        step_k(8'hFF, 8'h01, 3'b000, 9'h100, "hold_base");
        held = obs();
        for (int i = 0; i < 5; i++) begin
            bus.a = 8'($urandom);
            bus.b = 8'($urandom);
            bus.alu_sel = 3'($urandom);
            #1;
        end
        chk("hold_stable", obs(), held);

        // Reset mid-cycle with a result pending: cleared at once, discarded.
        step_k(8'h10, 8'h20, 3'b000, 9'h030, "pre_rst");
        bus.a = 8'h99;
        bus.b = 8'h11;
        bus.alu_sel = 3'b011;
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst", obs(), 9'h000);
        @(posedge clk);
        #2;
        chk("rst_edge", obs(), 9'h000);
        rst_n = 1'b1;
        #1;
        chk("rst_release", obs(), 9'h000);
        step_k(8'h37, 8'h37, 3'b000, 9'h06E, "post_rst_add");

        // Back-to-back random traffic.
        for (int i = 0; i < 300; i++)
            step(8'($urandom), 8'($urandom), 3'($urandom_range(0, 7)),
                 $sformatf("rand%0d", i));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
